// File: rtl/rh_cs2_silo.sv
`default_nettype none
// ============================================================================
// Module   : rh_cs2_silo
// Purpose  : RH11-style CS2 status/control register merged with an internal
//            data-buffer silo. IR/OR/MXF/DLT are derived from real silo
//            occupancy and accept/reject outcomes.
// Ports    : clk, rst (sync, active-high)
//            dev_reset/ctl_clr/clr_tre/clr_go  - error-clear sources
//            dev_lobyte/dev_hibyte/wr_data/cs2_write - program CS2 writes
//            cmd_go/ctl_rdy/set_wce/set_ned/set_nem - status strobes
//            xfer_rd                           - transfer direction
//            db_write/db_read/db_wdata/db_rdata - program side of silo
//            drv_strobe/drv_wdata/drv_rdata    - drive side of silo
//            silo_count, unit, cs2             - status outputs
// Options  : RH_CS2_PAT_EN - when defined, PAT (bit 4) is writable and any
//            accepted drive-side transfer while PAT=1 sets DPE (bit 8).
// Revision : 1.0 - initial release
// ============================================================================
module rh_cs2_silo #(
    parameter int UNIT_WIDTH = 3,
    parameter int SILO_DEPTH = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            dev_reset,
    input  logic                            dev_lobyte,
    input  logic                            dev_hibyte,
    input  logic [15:0]                     wr_data,
    input  logic                            cs2_write,
    input  logic                            cmd_go,
    input  logic                            clr_go,
    input  logic                            clr_tre,
    input  logic                            ctl_clr,
    input  logic                            ctl_rdy,
    input  logic                            set_wce,
    input  logic                            set_ned,
    input  logic                            set_nem,
    input  logic                            xfer_rd,
    input  logic                            db_write,
    input  logic                            db_read,
    input  logic [DATA_WIDTH-1:0]           db_wdata,
    input  logic                            drv_strobe,
    input  logic [DATA_WIDTH-1:0]           drv_wdata,
    output logic [DATA_WIDTH-1:0]           db_rdata,
    output logic [DATA_WIDTH-1:0]           drv_rdata,
    output logic [$clog2(SILO_DEPTH):0]     silo_count,
    output logic [UNIT_WIDTH-1:0]           unit,
    output logic [15:0]                     cs2
);

    localparam int c_PTR_W = $clog2(SILO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH   = c_CNT_W'(SILO_DEPTH);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem [SILO_DEPTH];
    logic [c_PTR_W-1:0]    r_wptr;
    logic [c_PTR_W-1:0]    r_rptr;
    logic [c_CNT_W-1:0]    r_count;
    logic                  r_dlt, r_wce, r_upe, r_ned, r_nem, r_pge, r_mxf, r_bai;
    logic [UNIT_WIDTH-1:0] r_unit;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic w_errclr, w_pge_clr, w_lo_wr, w_hi_wr, w_clr, w_flush;
    logic w_push_req, w_pop_req, w_push_ok, w_pop_ok, w_drv_ok;
    logic w_empty, w_full, w_prog_rej, w_drv_rej;
    logic [DATA_WIDTH-1:0] w_push_data;
    logic w_pat, w_dpe;
    logic [2:0] w_unit3;
    logic w_unused;

    assign w_errclr  = rst | dev_reset | ctl_clr | clr_tre | clr_go;
    // A GO-clear must not hide a programming error, so PGE ignores clr_go.
    assign w_pge_clr = rst | dev_reset | ctl_clr | clr_tre;
    assign w_lo_wr   = cs2_write & dev_lobyte;
    assign w_hi_wr   = cs2_write & dev_hibyte;
    assign w_clr     = w_lo_wr & wr_data[5];
    assign w_flush   = w_errclr | w_clr;

    assign w_push_req  = xfer_rd ? drv_strobe : db_write;
    assign w_pop_req   = xfer_rd ? db_read    : drv_strobe;
    assign w_push_data = xfer_rd ? drv_wdata  : db_wdata;

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == c_DEPTH);
    // Pop never bypasses a same-cycle push; a push into a full silo is
    // allowed only because the accepted pop frees a slot.
    assign w_pop_ok  = w_pop_req & ~w_empty;
    assign w_push_ok = w_push_req & (~w_full | w_pop_ok);
    assign w_drv_ok  = xfer_rd ? w_push_ok : w_pop_ok;

    // A flushing cycle discards the operations, so nothing is rejected.
    assign w_prog_rej = ~w_flush & (xfer_rd ? (db_read & ~w_pop_ok)
                                            : (db_write & ~w_push_ok));
    assign w_drv_rej  = ~w_flush & drv_strobe & ~w_drv_ok;

    // ------------------------------------------------------------------
    // Silo storage and pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SILO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (!w_flush && w_push_ok) begin
            r_mem[r_wptr] <= w_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
            r_count <= r_count + c_CNT_W'(w_push_ok) - c_CNT_W'(w_pop_ok);
        end
    end

    // ------------------------------------------------------------------
    // Error / status bits
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_errclr) begin
            r_dlt <= 1'b0;
            r_wce <= 1'b0;
            r_upe <= 1'b0;
            r_ned <= 1'b0;
            r_nem <= 1'b0;
            r_mxf <= 1'b0;
        end else begin
            if (w_drv_rej) r_dlt <= 1'b1;
            if (set_wce)   r_wce <= 1'b1;
            if (set_ned)   r_ned <= 1'b1;
            if (set_nem)   r_nem <= 1'b1;
            if (w_hi_wr)   r_upe <= wr_data[13];
            // Hardware detection of a missed transfer outranks software.
            if (w_prog_rej)   r_mxf <= 1'b1;
            else if (w_hi_wr) r_mxf <= wr_data[9];
        end
    end

    always_ff @(posedge clk) begin
        if (w_pge_clr) begin
            r_pge <= 1'b0;
        end else if (cmd_go && !ctl_rdy) begin
            r_pge <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_clr) begin
            r_bai  <= 1'b0;
            r_unit <= '0;
        end else if (w_lo_wr) begin
            r_unit <= wr_data[UNIT_WIDTH-1:0];
            if (ctl_rdy) begin
                r_bai <= wr_data[3];
            end
        end
    end

`ifdef RH_CS2_PAT_EN
    logic r_pat, r_dpe;

    always_ff @(posedge clk) begin
        if (rst || w_clr) begin
            r_pat <= 1'b0;
        end else if (w_lo_wr) begin
            r_pat <= wr_data[4];
        end
    end

    always_ff @(posedge clk) begin
        if (w_errclr) begin
            r_dpe <= 1'b0;
        end else if (r_pat && w_drv_ok && !w_flush) begin
            r_dpe <= 1'b1;
        end
    end

    assign w_pat = r_pat;
    assign w_dpe = r_dpe;
`else
    assign w_pat = 1'b0;
    assign w_dpe = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    generate
        if (UNIT_WIDTH >= 3) begin : g_unit_full
            assign w_unit3 = r_unit[2:0];
        end else begin : g_unit_pad
            assign w_unit3 = {{(3 - UNIT_WIDTH){1'b0}}, r_unit};
        end
    endgenerate

    assign db_rdata   = r_mem[r_rptr];
    assign drv_rdata  = r_mem[r_rptr];
    assign silo_count = r_count;
    assign unit       = r_unit;

    assign cs2 = {r_dlt, r_wce, r_upe, r_ned, r_nem, r_pge, r_mxf, w_dpe,
                  xfer_rd & ~w_empty,      // OR
                  ~xfer_rd & ~w_full,      // IR
                  w_clr, w_pat, r_bai, w_unit3};

    // Most CS2 write-data bits have no storage behind them.
    assign w_unused = ^wr_data;

endmodule
`default_nettype wire

// File: doc/rh_cs2_silo.md
Name: rh_cs2_silo

Overview:
Parametrised successor to the RH11 CS2 status register for the KS10 Massbus controller. It merges the CS2 error/control bits with an internal data-buffer silo of configurable depth, so IR/OR, MXF and DLT come from real silo occupancy rather than external strobes. It sits between the Unibus register decoder (program side) and the Massbus data path (drive side). Unit select width is configurable.

Parameters:
UNIT_WIDTH, 3, unit-select bits (1..3); unused CS2[2:0] bits read 0.
SILO_DEPTH, 4, silo entries (power of two, 2..64).
DATA_WIDTH, 16, silo word width (16..18).

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
dev_reset  in  1  UBA device reset
dev_lobyte  in  1  low-byte write enable
dev_hibyte  in  1  high-byte write enable
wr_data  in  16  Unibus write data
cs2_write  in  1  write strobe to CS2
cmd_go  in  1  GO command issued
clr_go  in  1  command clear
clr_tre  in  1  transfer-error clear
ctl_clr  in  1  controller clear
ctl_rdy  in  1  controller ready
set_wce  in  1  set write-check error
set_ned  in  1  set non-existent drive
set_nem  in  1  set non-existent memory
xfer_rd  in  1  direction: 1 = drive->program, 0 = program->drive
db_write  in  1  program write to data buffer
db_read  in  1  program read of data buffer
db_wdata  in  DATA_WIDTH  program write data
drv_strobe  in  1  drive-side word transfer (push if xfer_rd, else pop)
drv_wdata  in  DATA_WIDTH  drive push data
db_rdata  out  DATA_WIDTH  silo head (first-word fall-through)
drv_rdata  out  DATA_WIDTH  silo head (same word, drive view)
silo_count  out  $clog2(SILO_DEPTH)+1  occupancy
unit  out  UNIT_WIDTH  selected unit
cs2  out  16  CS2 image

Behaviour:
- cs2 = {DLT,WCE,UPE,NED,NEM,PGE,MXF,DPE,OR,IR,CLR,PAT,BAI,UNIT}, bits 15..0.
- errclr = rst|dev_reset|ctl_clr|clr_tre|clr_go; clears DLT,WCE,UPE,NED,NEM,MXF,DPE and flushes silo (count=0, pointers=0). PGE cleared by all except clr_go.
- CLR bit = cs2_write & dev_lobyte & wr_data[5], combinational, never stored; clears PAT,BAI,UNIT and flushes silo.
- Reset values: all flops 0, silo empty; cs2 = 16'o000100 (IR=1, write direction).
- WCE/NED/NEM: sticky set on set_* strobe; errclr wins same cycle.
- PGE: set on cmd_go & !ctl_rdy.
- UPE, MXF: writable via cs2_write & dev_hibyte (bits 13, 9); hardware set of MXF wins over a same-cycle write of 0.
- BAI: written only when ctl_rdy; UNIT written on low byte, wr_data[UNIT_WIDTH-1:0].
- Push source: xfer_rd ? drv_strobe : db_write. Pop source: xfer_rd ? db_read : drv_strobe.
- Push accepted if count<SILO_DEPTH, or full with accepted pop same cycle. Pop accepted only if count>0 (no bypass of same-cycle push).
- Rejected program-side op (db_write when full / db_read when empty) -> MXF=1, silo unchanged.
- Rejected drive-side op -> DLT=1, silo unchanged.
- Data visible on db_rdata/drv_rdata the cycle after push into empty silo. Pointers wrap modulo SILO_DEPTH.
- IR = !xfer_rd & (count<SILO_DEPTH); OR = xfer_rd & (count>0). Combinational from registered count.
- Flush/errclr beats any same-cycle push/pop. Changing xfer_rd does not flush.

Optional Feature:
RH_CS2_PAT_EN: defined -> PAT (bit 4) writable on low byte; each accepted drive-side op while PAT=1 sets DPE (sticky, errclr clears). Undefined -> PAT and DPE read 0, writes ignored.

Test Plan:
- rst pulse -> cs2=16'o000100, silo_count=0, unit=0.
- xfer_rd=0, 4 db_write (DEPTH=4) -> IR=0, count=4; 5th db_write -> MXF=1, count=4; 4 drv_strobe -> drv_rdata in FIFO order, IR=1.
- xfer_rd=1, drv_strobe on full + db_read same cycle -> push accepted, count stays 4, no DLT; drv_strobe on empty write direction -> DLT=1.
- cmd_go with ctl_rdy=0 -> PGE=1; clr_go -> PGE stays 1, MXF/DLT cleared; clr_tre -> PGE=0.
- cs2_write lobyte wr_data=16'o000045 -> CLR pulse, UNIT=0, silo flushed; next write 16'o000015 with ctl_rdy=1 -> BAI=1, UNIT=5.
- RH_CS2_PAT_EN defined, PAT=1, one drv_strobe -> DPE=1; undefined -> cs2[8]=cs2[4]=0.
